// File: rtl/fixed_ascii_pkg.sv
// rtl/fixed_ascii_pkg.sv - shared types and constants for the fixed-point to ASCII converter
package fixed_ascii_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INT,
      DOT,
      FRAC,
      NL
   } state_t;

   localparam int INT_W  = 8;
   localparam int FRAC_W = 23;

   localparam logic [7:0] CH_ZERO = 8'h30;
   localparam logic [7:0] CH_DOT  = 8'h2E;
   localparam logic [7:0] CH_NL   = 8'h0A;

   // ASCII code of one decimal digit
   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return CH_ZERO + {4'b0000, d};
   endfunction

   // Select a BCD digit by position: 2 hundreds, 1 tens, 0 units
   function automatic logic [3:0] pick_digit(input logic [3:0] h, input logic [3:0] t,
                                             input logic [3:0] u, input logic [1:0] pos);
      case (pos)
         2'd2:    return h;
         2'd1:    return t;
         default: return u;
      endcase
   endfunction

endpackage

// File: rtl/bin_to_bcd8.sv
// rtl/bin_to_bcd8.sv - combinational 8-bit binary to three BCD digits (double dabble)
module bin_to_bcd8 (
   input  logic [7:0] bin,
   output logic [3:0] hund,
   output logic [3:0] tens,
   output logic [3:0] units
);

   logic [19:0] sh;

   // Shift-and-add-3: correct each BCD nibble before every shift
   always_comb begin
      sh = {12'd0, bin};
      for (int i = 0; i < 8; i++) begin
         if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
         if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
         if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
         sh = sh << 1;
      end
   end

   assign hund  = sh[19:16];
   assign tens  = sh[15:12];
   assign units = sh[11:8];

endmodule

// File: rtl/fixed_to_ascii.sv
// rtl/fixed_to_ascii.sv - Q8.23 to "III.FFFFFF" character stream; FIX_ASCII_NEWLINE_EN appends a newline
module fixed_to_ascii
   import fixed_ascii_pkg::*;
#(
   parameter int FRAC_DIGITS = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INT_W-1:0]  in_int,
   input  logic [FRAC_W-1:0] in_frac,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_char,
   output logic              out_last
);

`ifdef FIX_ASCII_NEWLINE_EN
   localparam bit NL_EN = 1'b1;
`else
   localparam bit NL_EN = 1'b0;
`endif

   localparam logic [3:0] FRAC_CNT_INIT = 4'(FRAC_DIGITS - 1);
   localparam bit         ONE_FRAC_LAST = (FRAC_DIGITS == 1) && !NL_EN;

   state_t             state, state_nx;
   logic [FRAC_W-1:0]  frac_reg, frac_nx;
   logic [3:0]         hund_r, tens_r, units_r;
   logic [3:0]         hund_nx, tens_nx, units_nx;
   logic [1:0]         pos, pos_nx;
   logic [3:0]         cnt, cnt_nx;
   logic               out_valid_nx, out_last_nx;
   logic [7:0]         out_char_nx;

   logic [3:0]         bcd_h, bcd_t, bcd_u;
   logic [1:0]         n_int;
   logic [26:0]        prod;
   logic               hs;

   bin_to_bcd8 u_bcd (
      .bin   (in_int),
      .hund  (bcd_h),
      .tens  (bcd_t),
      .units (bcd_u)
   );

   assign in_ready = (state == IDLE);
   assign hs       = out_valid && out_ready;
   assign n_int    = (in_int >= 8'd100) ? 2'd3 : (in_int >= 8'd10) ? 2'd2 : 2'd1;
   // Multiply by ten as shift-and-add; the carry out of the fraction is the next digit
   assign prod     = ({4'b0000, frac_reg} << 3) + ({4'b0000, frac_reg} << 1);

   // State and output registers; reset aborts any word in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         frac_reg  <= '0;
         hund_r    <= 4'd0;
         tens_r    <= 4'd0;
         units_r   <= 4'd0;
         pos       <= 2'd0;
         cnt       <= 4'd0;
         out_valid <= 1'b0;
         out_char  <= 8'h00;
         out_last  <= 1'b0;
      end else begin
         state     <= state_nx;
         frac_reg  <= frac_nx;
         hund_r    <= hund_nx;
         tens_r    <= tens_nx;
         units_r   <= units_nx;
         pos       <= pos_nx;
         cnt       <= cnt_nx;
         out_valid <= out_valid_nx;
         out_char  <= out_char_nx;
         out_last  <= out_last_nx;
      end
   end

   // Next-state and next-character; everything holds unless a word is accepted or a character handshakes
   always_comb begin
      state_nx     = state;
      frac_nx      = frac_reg;
      hund_nx      = hund_r;
      tens_nx      = tens_r;
      units_nx     = units_r;
      pos_nx       = pos;
      cnt_nx       = cnt;
      out_valid_nx = out_valid;
      out_char_nx  = out_char;
      out_last_nx  = out_last;
      case (state)
         IDLE: begin
            if (in_valid) begin
               hund_nx      = bcd_h;
               tens_nx      = bcd_t;
               units_nx     = bcd_u;
               frac_nx      = in_frac;
               pos_nx       = n_int - 2'd1;
               out_char_nx  = digit_char(pick_digit(bcd_h, bcd_t, bcd_u, n_int - 2'd1));
               out_valid_nx = 1'b1;
               out_last_nx  = 1'b0;
               state_nx     = INT;
            end
         end
         INT: begin
            if (hs) begin
               if (pos != 2'd0) begin
                  pos_nx      = pos - 2'd1;
                  out_char_nx = digit_char(pick_digit(hund_r, tens_r, units_r, pos - 2'd1));
               end else begin
                  out_char_nx = CH_DOT;
                  state_nx    = DOT;
               end
            end
         end
         DOT: begin
            if (hs) begin
               out_char_nx = digit_char(prod[26:23]);
               frac_nx     = prod[22:0];
               cnt_nx      = FRAC_CNT_INIT;
               out_last_nx = ONE_FRAC_LAST;
               state_nx    = FRAC;
            end
         end
         FRAC: begin
            if (hs) begin
               if (cnt != 4'd0) begin
                  out_char_nx = digit_char(prod[26:23]);
                  frac_nx     = prod[22:0];
                  cnt_nx      = cnt - 4'd1;
                  out_last_nx = (cnt == 4'd1) && !NL_EN;
               end else begin
`ifdef FIX_ASCII_NEWLINE_EN
                  out_char_nx  = CH_NL;
                  out_last_nx  = 1'b1;
                  state_nx     = NL;
`else
                  out_valid_nx = 1'b0;
                  out_last_nx  = 1'b0;
                  state_nx     = IDLE;
`endif
               end
            end
         end
`ifdef FIX_ASCII_NEWLINE_EN
         NL: begin
            if (hs) begin
               out_valid_nx = 1'b0;
               out_last_nx  = 1'b0;
               state_nx     = IDLE;
            end
         end
`endif
         default: begin
            out_valid_nx = 1'b0;
            out_last_nx  = 1'b0;
            state_nx     = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fixed_to_ascii.sv
// tb/tb_fixed_to_ascii.sv - scoreboard bench for fixed_to_ascii
module tb_fixed_to_ascii;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_int;
   logic [22:0] in_frac;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_char;
   logic        out_last;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [8:0]  sb[$];
   logic [8:0]  got;

   fixed_to_ascii #(.FRAC_DIGITS(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_int    (in_int),
      .in_frac   (in_frac),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_char  (out_char),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected text: integer in decimal, fraction truncated to six digits
   function automatic string model(input logic [7:0] iv, input logic [22:0] fv);
      longint f;
      string  s;
      f = (longint'(fv) * 64'd1000000) >> 23;
      s = $sformatf("%0d.%06d", iv, f);
`ifdef FIX_ASCII_NEWLINE_EN
      s = {s, "\n"};
`endif
      return s;
   endfunction

   // Scoreboard consumer: each handshake pops one expected character
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL sb_unexpected observed=%0h expected=none", out_char);
         end else begin
            got = sb.pop_front();
            chk("sb_char", {24'd0, out_char}, {24'd0, got[7:0]});
            chk("sb_last", {31'd0, out_last}, {31'd0, got[8]});
         end
      end
   end

   // Starts in the drive phase (just after a rising edge) with the DUT idle
   task automatic send(input logic [7:0] iv, input logic [22:0] fv, input int stall_idx, input int stall_n);
      string      s;
      logic [8:0] e;
      s = model(iv, fv);
      for (int k = 0; k < s.len(); k++) begin
         e = {(k == s.len() - 1), 8'(s[k])};
         sb.push_back(e);
      end
      in_int   = iv;
      in_frac  = fv;
      in_valid = 1'b1;
      @(negedge clk);
      chk("ready_idle", {31'd0, in_ready}, 32'd1);
      chk("bubble_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #2;
      in_valid = 1'b0;
      in_int   = 8'hA5;
      in_frac  = 23'h155555;
      for (int k = 0; k < s.len(); k++) begin
         if (k == stall_idx) begin
            out_ready = 1'b0;
            for (int j = 0; j < stall_n; j++) begin
               @(negedge clk);
               chk("bp_valid", {31'd0, out_valid}, 32'd1);
               chk("bp_char", {24'd0, out_char}, {24'd0, 8'(s[k])});
               @(posedge clk); #2;
            end
            out_ready = 1'b1;
         end
         @(negedge clk);
         chk((k == 0) ? "first_latency" : "stream_valid", {31'd0, out_valid}, 32'd1);
         if (k == 0) chk("busy_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #2;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_int    = 8'd0;
      in_frac   = 23'd0;
      out_ready = 1'b1;
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_char", {24'd0, out_char}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;

      send(8'd3,   23'h400000, -1, 0);
      send(8'd0,   23'h000000, -1, 0);
      send(8'd255, 23'h7FFFFF, -1, 0);
      send(8'd12,  23'h200000, 1, 3);
      send(8'd9,   23'h19999A, -1, 0);

      // Abort "100.750000" while the '.' is presented
      sb.push_back({1'b0, 8'h31});
      sb.push_back({1'b0, 8'h30});
      sb.push_back({1'b0, 8'h30});
      in_int   = 8'd100;
      in_frac  = 23'h600000;
      in_valid = 1'b1;
      @(negedge clk);
      chk("rst_word_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #2;
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_word_valid", {31'd0, out_valid}, 32'd1);
         @(posedge clk); #2;
      end
      out_ready = 1'b0;
      @(negedge clk);
      chk("rst_pre_dot", {24'd0, out_char}, 32'h2E);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_char", {24'd0, out_char}, 32'd0);
      chk("abort_last", {31'd0, out_last}, 32'd0);
      @(posedge clk); #2;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      chk("abort_sb_drained", sb.size(), 32'd0);

      send(8'd100, 23'h600000, -1, 0);
      send(8'd7,   23'h000000, -1, 0);
      send(8'd42,  23'h000001, 2, 2);

      @(negedge clk);
      chk("end_idle_valid", {31'd0, out_valid}, 32'd0);
      chk("end_sb_empty", sb.size(), 32'd0);
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
